// File: rtl/ex_mdu_pkg.sv
// ---------------------------------------------------------------------------
// ex_mdu_pkg
//   Shared definitions for the EX-stage multiply/divide unit: operation
//   encodings (3 bit, total), FSM state encodings and small decode helpers.
// ---------------------------------------------------------------------------
package ex_mdu_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_OP_MULT  = 3'd0,
    MDU_OP_MULTU = 3'd1,
    MDU_OP_MADD  = 3'd2,
    MDU_OP_MADDU = 3'd3,
    MDU_OP_MSUB  = 3'd4,
    MDU_OP_MSUBU = 3'd5,
    MDU_OP_DIV   = 3'd6,
    MDU_OP_DIVU  = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    MDU_ST_IDLE = 3'd0,
    MDU_ST_MUL  = 3'd1,
    MDU_ST_DIV  = 3'd2,
    MDU_ST_FIX  = 3'd3,
    MDU_ST_DONE = 3'd4
  } mdu_state_e;

  // Signed flavours work on magnitudes and get their sign back in FIX.
  function automatic logic op_is_signed(input mdu_op_e op);
    case (op)
      MDU_OP_MULT, MDU_OP_MADD, MDU_OP_MSUB, MDU_OP_DIV: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    case (op)
      MDU_OP_DIV, MDU_OP_DIVU: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_mdu_div_core.sv
// ---------------------------------------------------------------------------
// ex_mdu_div_core
//   Restoring divider, one quotient bit per step, unsigned magnitudes only.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     clear_i         synchronous clear of all state (abort)
//     load_i          latch dividend/divisor, zero the partial remainder
//     step_i          retire one quotient bit (MSB first)
//     dividend_i      dividend magnitude
//     divisor_i       divisor magnitude (never zero when loaded)
//     quotient_o      quotient after DATA_W steps
//     remainder_o     remainder after DATA_W steps
// ---------------------------------------------------------------------------
module ex_mdu_div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] dvs_r;
  logic [DATA_W:0]   shifted_s;
  logic              ge_s;
  logic [DATA_W-1:0] diff_s;

  // Trial subtraction: the partial remainder stays below the divisor, so the
  // true difference always fits DATA_W bits when it is non-negative.
  always_comb begin
    shifted_s = {rem_r, quo_r[DATA_W-1]};
    ge_s      = (shifted_s >= {1'b0, dvs_r});
    diff_s    = shifted_s[DATA_W-1:0] - dvs_r;
  end

  // Dividend shifts out of quo_r as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      quo_r <= {DATA_W{1'b0}};
      rem_r <= {DATA_W{1'b0}};
      dvs_r <= {DATA_W{1'b0}};
    end else if (load_i) begin
      quo_r <= dividend_i;
      rem_r <= {DATA_W{1'b0}};
      dvs_r <= divisor_i;
    end else if (step_i) begin
      quo_r <= {quo_r[DATA_W-2:0], ge_s};
      rem_r <= ge_s ? diff_s : shifted_s[DATA_W-1:0];
    end else begin
      quo_r <= quo_r;
      rem_r <= rem_r;
      dvs_r <= dvs_r;
    end
  end

  assign quotient_o  = quo_r;
  assign remainder_o = rem_r;

endmodule

// File: rtl/ex_mdu.sv
// ---------------------------------------------------------------------------
// ex_mdu
//   Iterative multiply/divide unit for the EX stage. Runs MULT/MULTU/MADD/
//   MADDU/MSUB/MSUBU/DIV/DIVU over several cycles behind a start/done
//   handshake and returns a {HI,LO} result (DIV*: {remainder, quotient}).
//   Multiply retires MUL_BITS multiplier bits per cycle; divide uses
//   ex_mdu_div_core at one bit per cycle. FIX applies signs / accumulate.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     start_i      request, sampled only in IDLE or DONE
//     op_i         operation (ex_mdu_pkg::mdu_op_e)
//     opa_i/opb_i  rs (dividend) / rt (divisor) operands
//     hilo_i       forwarded {HI,LO} accumulator for MADD*/MSUB*
//     annul_i      abort in-flight op, highest priority after rst
//     busy_o       op in flight (MUL, DIV, FIX)
//     done_o       one-cycle pulse, result_o valid
//     result_o     {HI,LO}, held until a new result is produced
//     div_zero_o   only with MDU_DIVZERO_FLAG_EN: pulses with done_o for a
//                  divide by zero
//   Configuration macro: MDU_DIVZERO_FLAG_EN (default undefined).
// ---------------------------------------------------------------------------
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_W-1:0]     opa_i,
  input  logic [DATA_W-1:0]     opb_i,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic                  annul_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2*DATA_W-1:0]   result_o
`ifdef MDU_DIVZERO_FLAG_EN
  ,
  output logic                  div_zero_o
`endif
);

  localparam int N_MUL = DATA_W / MUL_BITS;
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int PP_W  = DATA_W + MUL_BITS;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(N_MUL - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic sgn);
    if (sgn && v[DATA_W-1]) return -v;
    else                    return v;
  endfunction

  mdu_state_e                state_r, next_s;
  mdu_op_e                   op_s, op_r;
  logic                      accept_s, divz_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [2*DATA_W-1:0]       hilo_r, acc_r, acc_next_s;
  logic [DATA_W-1:0]         mcand_r, mplier_r;
  logic                      neg_prod_r, neg_rem_r;
  logic [DATA_W-1:0]         mag_a_s, mag_b_s;
  logic [PP_W-1:0]           pp_s;
  logic [2*DATA_W+MUL_BITS-1:0] acc_wide_s;
  logic [DATA_W-1:0]         quo_s, rem_s, quo_sgn_s, rem_sgn_s;
  logic [2*DATA_W-1:0]       prod_s, fix_s;
  logic                      busy_r, done_r;
  logic [2*DATA_W-1:0]       result_r;
  logic                      divz_r;

  assign op_s    = mdu_op_e'(op_i);
  assign mag_a_s = magnitude(opa_i, op_is_signed(op_s));
  assign mag_b_s = magnitude(opb_i, op_is_signed(op_s));

  // Next-state logic; annul wins over everything, divide by zero skips to DONE.
  always_comb begin
    next_s   = state_r;
    accept_s = 1'b0;
    divz_s   = 1'b0;
    if (annul_i) begin
      next_s = MDU_ST_IDLE;
    end else begin
      case (state_r)
        MDU_ST_IDLE, MDU_ST_DONE: begin
          if (start_i) begin
            if (op_is_div(op_s) && (opb_i == {DATA_W{1'b0}})) begin
              next_s = MDU_ST_DONE;
              divz_s = 1'b1;
            end else begin
              accept_s = 1'b1;
              if (op_is_div(op_s)) next_s = MDU_ST_DIV;
              else                 next_s = MDU_ST_MUL;
            end
          end else begin
            next_s = MDU_ST_IDLE;
          end
        end
        MDU_ST_MUL: begin
          if (cnt_r == MUL_LAST) next_s = MDU_ST_FIX;
          else                   next_s = MDU_ST_MUL;
        end
        MDU_ST_DIV: begin
          if (cnt_r == DIV_LAST) next_s = MDU_ST_FIX;
          else                   next_s = MDU_ST_DIV;
        end
        MDU_ST_FIX: next_s = MDU_ST_DONE;
        default:    next_s = MDU_ST_IDLE;
      endcase
    end
  end

  // One radix-2^MUL_BITS step: add digit*multiplicand into the high half,
  // then shift the whole accumulator right by one digit.
  always_comb begin
    pp_s = {{MUL_BITS{1'b0}}, acc_r[2*DATA_W-1:DATA_W]}
         + ({{MUL_BITS{1'b0}}, mcand_r} * {{DATA_W{1'b0}}, mplier_r[MUL_BITS-1:0]});
    acc_wide_s = {pp_s, acc_r[DATA_W-1:0]};
    acc_next_s = (2*DATA_W)'(acc_wide_s >> MUL_BITS);
  end

  // Sign restoration and accumulate, evaluated during FIX.
  always_comb begin
    if (neg_prod_r) begin
      prod_s    = -acc_r;
      quo_sgn_s = -quo_s;
    end else begin
      prod_s    = acc_r;
      quo_sgn_s = quo_s;
    end
    if (neg_rem_r) rem_sgn_s = -rem_s;
    else           rem_sgn_s = rem_s;
    case (op_r)
      MDU_OP_MULT, MDU_OP_MULTU: fix_s = prod_s;
      MDU_OP_MADD, MDU_OP_MADDU: fix_s = hilo_r + prod_s;
      MDU_OP_MSUB, MDU_OP_MSUBU: fix_s = hilo_r - prod_s;
      MDU_OP_DIV,  MDU_OP_DIVU:  fix_s = {rem_sgn_s, quo_sgn_s};
      default:                   fix_s = prod_s;
    endcase
  end

  // Operand latch at accept and multiply iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r       <= MDU_OP_MULT;
      hilo_r     <= {(2*DATA_W){1'b0}};
      acc_r      <= {(2*DATA_W){1'b0}};
      mcand_r    <= {DATA_W{1'b0}};
      mplier_r   <= {DATA_W{1'b0}};
      neg_prod_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      op_r       <= op_s;
      hilo_r     <= hilo_i;
      acc_r      <= {(2*DATA_W){1'b0}};
      mcand_r    <= mag_a_s;
      mplier_r   <= mag_b_s;
      neg_prod_r <= op_is_signed(op_s) & (opa_i[DATA_W-1] ^ opb_i[DATA_W-1]);
      neg_rem_r  <= op_is_signed(op_s) & opa_i[DATA_W-1];
      cnt_r      <= {CNT_W{1'b0}};
    end else if (state_r == MDU_ST_MUL) begin
      acc_r      <= acc_next_s;
      mplier_r   <= mplier_r >> MUL_BITS;
      cnt_r      <= cnt_r + CNT_ONE;
    end else if (state_r == MDU_ST_DIV) begin
      cnt_r      <= cnt_r + CNT_ONE;
    end else begin
      cnt_r      <= cnt_r;
    end
  end

  ex_mdu_div_core #(.DATA_W(DATA_W)) u_div_core (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (annul_i),
    .load_i      (accept_s & op_is_div(op_s)),
    .step_i      ((state_r == MDU_ST_DIV) & ~annul_i),
    .dividend_i  (mag_a_s),
    .divisor_i   (mag_b_s),
    .quotient_o  (quo_s),
    .remainder_o (rem_s)
  );

  // State register and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= MDU_ST_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      divz_r   <= 1'b0;
      result_r <= {(2*DATA_W){1'b0}};
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s == MDU_ST_MUL) || (next_s == MDU_ST_DIV) ||
                 (next_s == MDU_ST_FIX);
      done_r  <= (next_s == MDU_ST_DONE);
      divz_r  <= divz_s;
      // An annulled FIX must leave the previous result visible.
      if ((state_r == MDU_ST_FIX) && !annul_i) result_r <= fix_s;
      else if (divz_s)                         result_r <= {(2*DATA_W){1'b0}};
      else                                     result_r <= result_r;
    end
  end

  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign result_o = result_r;

`ifdef MDU_DIVZERO_FLAG_EN
  assign div_zero_o = divz_r;
`else
  logic unused_divz_s;
  assign unused_divz_s = divz_r;
`endif

endmodule
